// File: rtl/alu_pipe_if.sv
// Handshake and operand/result bundle for alu_pipe.
// master drives operands and out_ready; slave is the ALU.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;
    logic             illegal;

    modport master (
        output in_valid, op, sub, a, b, out_ready,
        input  in_ready, out_valid, result, flags, illegal
    );

    modport slave (
        input  in_valid, op, sub, a, b, out_ready,
        output in_ready, out_valid, result, flags, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU: one op per accepted beat, result held behind valid/ready.
// Flags are {Z, V, N}; each op class updates only its own subset.
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANE  = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_pipe_if.slave   bus
);
    localparam int unsigned NLANE = WIDTH / LANE;

    typedef enum logic [3:0] {
        OpAdd    = 4'b0000,
        OpXor    = 4'b0001,
        OpRed    = 4'b0010,
        OpSll    = 4'b0011,
        OpSra    = 4'b0100,
        OpRor    = 4'b0101,
        OpPaddsb = 4'b0110,
        OpLlb    = 4'b0111,
        OpLhb    = 4'b1000
    } op_e;

    localparam logic [WIDTH-1:0] SatMax  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE-1:0]  LaneMax = {1'b0, {(LANE-1){1'b1}}};
    localparam logic [LANE-1:0]  LaneMin = {1'b1, {(LANE-1){1'b0}}};

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [2:0]       flags_q;
    logic             illegal_q;

    logic             accept;
    logic [WIDTH-1:0] result_d;
    logic [2:0]       flags_d;
    logic             illegal_d;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum_raw;
    logic               ovf;
    logic [WIDTH-1:0]   add_res;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] rot_full;
    logic [LANE:0]      lane_sum;
    logic [WIDTH-1:0]   padd;
    logic [2*WIDTH-1:0] ab;
    logic [WIDTH-1:0]   red;

    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    // Datapath: every candidate result is computed in parallel, then op selects.
    always_comb begin
        // Subtraction as a + ~b + 1; overflow judged on the effective operands.
        b_eff   = bus.sub ? ~bus.b : bus.b;
        sum_raw = bus.a + b_eff + WIDTH'(bus.sub);
        ovf     = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_raw[WIDTH-1] != bus.a[WIDTH-1]);
        add_res = ovf ? (bus.a[WIDTH-1] ? SatMin : SatMax) : sum_raw;

        sh       = bus.b[SHW-1:0];
        rot_full = {bus.a, bus.a} >> sh;

        padd     = '0;
        lane_sum = '0;
        for (int unsigned l = 0; l < NLANE; l++) begin
            lane_sum = {bus.a[l*LANE+LANE-1], bus.a[l*LANE +: LANE]}
                     + {bus.b[l*LANE+LANE-1], bus.b[l*LANE +: LANE]};
            if (lane_sum[LANE] != lane_sum[LANE-1]) begin
                padd[l*LANE +: LANE] = lane_sum[LANE] ? LaneMin : LaneMax;
            end else begin
                padd[l*LANE +: LANE] = lane_sum[LANE-1:0];
            end
        end

        // Lane sum range is far inside WIDTH bits, so plain wrap-free accumulation.
        ab  = {bus.b, bus.a};
        red = '0;
        for (int unsigned l = 0; l < 2 * NLANE; l++) begin
            red = red + {{(WIDTH-LANE){ab[l*LANE+LANE-1]}}, ab[l*LANE +: LANE]};
        end
    end

    // Result, illegal flag and {Z,V,N} next-state selection by opcode.
    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        flags_d   = flags_q;
        case (bus.op)
            OpAdd: begin
                result_d = add_res;
                flags_d  = {add_res == '0, ovf, add_res[WIDTH-1]};
            end
            OpXor: begin
                result_d   = bus.a ^ bus.b;
                flags_d[2] = (result_d == '0);
            end
            OpSll: begin
                result_d   = bus.a << sh;
                flags_d[2] = (result_d == '0);
            end
            OpSra: begin
                result_d   = WIDTH'($signed(bus.a) >>> sh);
                flags_d[2] = (result_d == '0);
            end
            OpRor: begin
                result_d   = rot_full[WIDTH-1:0];
                flags_d[2] = (result_d == '0);
            end
            OpRed:    result_d = red;
            OpPaddsb: result_d = padd;
            OpLlb:    result_d = {bus.a[WIDTH-1:WIDTH/2], bus.b[WIDTH/2-1:0]};
            OpLhb:    result_d = {bus.b[WIDTH/2-1:0], bus.a[WIDTH/2-1:0]};
            default:  illegal_d = 1'b1;
        endcase
    end

    // Output register: load on accept, otherwise drain on out_ready and hold data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 3'b000;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            flags_q     <= flags_d;
            illegal_q   <= illegal_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.illegal   = illegal_q;
endmodule
